// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: credit-based FIFO pop controller feeding a 2-entry skid buffer
module fifo_pop_ctrl #(
  parameter int DATA_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic                 almost_empty,
  input  logic                 fifo_error,
  input  logic [DATA_SIZE-1:0] data_out_pop,
  input  logic                 ready_in,
  input  logic                 pause_in,
  output logic                 read,
  output logic                 valid_out,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [7:0]           pop_count,
  output logic                 err_sticky,
  output logic [1:0]           state
);
  localparam int BUF_DEPTH = 2;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2;
  logic [1:0] state_q, state_d, occ_q, occ_d, occ_sh;
  logic [DATA_SIZE-1:0] buf_q [BUF_DEPTH];
  logic [DATA_SIZE-1:0] buf_d [BUF_DEPTH];
  logic [7:0] cnt_q;
  logic [2:0] credit;
  logic rd_q, err_q, xfer, ovf;
  assign valid_out  = occ_q != 2'd0;
  assign data_out   = buf_q[0];
  assign pop_count  = cnt_q;
  assign err_sticky = err_q;
  assign state      = state_q;
  assign xfer       = valid_out & ready_in;
  // words held plus the one in flight, minus the one leaving this cycle
  assign credit = {1'b0, occ_q} + {2'b0, rd_q} - {2'b0, xfer};
  assign read   = (state_q == RUN) & ~fifo_empty & (credit <= 3'd1) & ~(almost_empty & rd_q);
  assign ovf    = rd_q & (occ_q == 2'd2) & ~xfer;
  assign occ_sh = occ_q - {1'b0, xfer};
  assign state_d = !enable ? IDLE :
                   (state_q == IDLE) ? (pause_in ? IDLE : RUN) :
                   (pause_in ? HOLD : RUN);
  always_comb begin
    buf_d[0] = xfer ? buf_q[1] : buf_q[0];
    buf_d[1] = buf_q[1];
    occ_d    = occ_sh;
    if (rd_q && !ovf) begin
      buf_d[occ_sh[0]] = data_out_pop;
      occ_d = occ_sh + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      occ_q    <= 2'd0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      rd_q     <= read;
      err_q    <= err_q | fifo_error | ovf;
      cnt_q    <= cnt_q + {7'd0, xfer};
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
    end
  end
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: directed self-checking bench with a behavioural source FIFO
module tb_fifo_pop_ctrl;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, fifo_error = 1'b0, ready_in = 1'b0, pause_in = 1'b0;
  logic fifo_empty, almost_empty, read, valid_out, err_sticky;
  logic [9:0] dpop = '0, data_out;
  logic [7:0] pop_count;
  logic [1:0] state;
  logic [9:0] mem [0:511];
  int wr_ptr = 0, rd_ptr = 0, unf = 0;
  int checks = 0, fails = 0;
  int nrd, cur, mx, viol;
  logic prev;
  logic [9:0] log_q [$];

  fifo_pop_ctrl #(.DATA_SIZE(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .almost_empty(almost_empty), .fifo_error(fifo_error), .data_out_pop(dpop),
    .ready_in(ready_in), .pause_in(pause_in), .read(read), .valid_out(valid_out),
    .data_out(data_out), .pop_count(pop_count), .err_sticky(err_sticky), .state(state)
  );

  always #5 clk = ~clk;

  // source FIFO: read data appears one cycle after the pop strobe
  assign fifo_empty   = rd_ptr >= wr_ptr;
  assign almost_empty = (wr_ptr - rd_ptr) <= 1;
  always @(posedge clk)
    if (read) begin
      if (rd_ptr < wr_ptr) begin
        dpop   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end else unf <= unf + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    log_q.delete();
    nrd = 0; cur = 0; mx = 0; viol = 0; prev = 1'b0;
  endtask

  task automatic load(input int base, input int n);
    wr_ptr = rd_ptr;
    for (int i = 0; i < n; i++) mem[wr_ptr + i] = 10'((base + i) & 'h3ff);
    wr_ptr = wr_ptr + n;
  endtask

  task automatic cyc();
    @(negedge clk);
    if (read) begin
      nrd++; cur++;
      if (cur > mx) mx = cur;
      if (prev && almost_empty) viol++;
    end else cur = 0;
    prev = read;
    if (valid_out && ready_in) log_q.push_back(data_out);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic en);
    enable = en; reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    clear();
  endtask

  task automatic chk_seq(input string tag, input int base, input int n);
    int bad = 0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] != 10'((base + i) & 'h3ff)) bad++;
    chk({tag, "_len"}, log_q.size(), n);
    chk({tag, "_order"}, bad, 0);
  endtask

  initial begin
    clear();
    do_reset(1'b0);
    chk("rst_state", state, 0);
    chk("rst_read", read, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cnt", pop_count, 0);
    chk("rst_err", err_sticky, 0);

    // continuous stream of 8 words
    load('h001, 8);
    enable = 1'b1; ready_in = 1'b1;
    repeat (40) cyc();
    chk_seq("stream", 'h001, 8);
    chk("stream_cnt", pop_count, 8);
    chk("stream_reads", nrd, 8);
    chk("stream_run", mx, 7);
    chk("stream_guard", viol, 0);

    // back-pressure: credit limits to two outstanding words
    do_reset(1'b0);
    load('h010, 8);
    enable = 1'b1; ready_in = 1'b0;
    repeat (5) cyc();
    chk("bp_reads", nrd, 2);
    chk("bp_valid", valid_out, 1);
    chk("bp_frozen", data_out, 'h010);
    cyc();
    chk("bp_hold", data_out, 'h010);
    ready_in = 1'b1;
    repeat (30) cyc();
    chk_seq("bp", 'h010, 8);
    chk("bp_cnt", pop_count, 8);

    // single word with almost_empty
    do_reset(1'b0);
    load('h155, 1);
    enable = 1'b1; ready_in = 1'b1;
    repeat (10) cyc();
    chk("one_reads", nrd, 1);
    chk_seq("one", 'h155, 1);
    chk("one_err", err_sticky, 0);
    chk("one_guard", viol, 0);

    // pause mid-stream
    do_reset(1'b0);
    load('h020, 8);
    enable = 1'b1; ready_in = 1'b1;
    repeat (4) cyc();
    pause_in = 1'b1;
    cyc();
    chk("pause_state", state, 2);
    chk("pause_read", read, 0);
    repeat (5) cyc();
    chk("pause_reads", nrd, 4);
    chk("pause_drain", log_q.size(), 4);
    pause_in = 1'b0;
    cyc();
    chk("resume_state", state, 1);
    chk("resume_read", read, 1);
    repeat (30) cyc();
    chk_seq("pause", 'h020, 8);
    chk("pause_cnt", pop_count, 8);

    // 300 transfers wrap the counter
    do_reset(1'b0);
    load('h040, 300);
    enable = 1'b1; ready_in = 1'b1;
    for (int k = 0; k < 1000 && log_q.size() < 300; k++) cyc();
    chk_seq("wrap", 'h040, 300);
    chk("wrap_cnt", pop_count, 44);
    chk("wrap_err0", err_sticky, 0);
    fifo_error = 1'b1;
    cyc();
    fifo_error = 1'b0;
    chk("err_set", err_sticky, 1);
    repeat (3) cyc();
    chk("err_hold", err_sticky, 1);

    // reset while streaming
    load('h030, 8);
    clear();
    repeat (4) cyc();
    do_reset(1'b1);
    chk("mrst_state", state, 0);
    chk("mrst_read", read, 0);
    chk("mrst_valid", valid_out, 0);
    chk("mrst_data", data_out, 0);
    chk("mrst_cnt", pop_count, 0);
    chk("mrst_err", err_sticky, 0);
    cyc();
    chk("mrst_run", state, 1);
    chk("mrst_rd", read, 1);
    repeat (20) cyc();
    chk("mrst_last", log_q.size() > 0 ? 32'(log_q[log_q.size() - 1]) : 32'hffff, 'h037);
    chk("underflow", unf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
